// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode stage: opcodes, ALU and immediate-select
// encodings, the ID/EX bundle layout, and the helpers that decode ALU ops and immediates.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    // IMM_NONE marks formats without an immediate; they produce zero.
    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_J    = 3'd3,
        IMM_U    = 3'd4,
        IMM_NONE = 3'd5
    } imm_src_e;

    typedef struct packed {
        logic              regWrite;
        logic              memWrite;
        logic              memToReg;
        logic              aluSrc;
        logic              branch;
        logic              bne;
        logic              jump;
        alu_ctrl_e         aluControl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   immExt;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcPlus4;
    } idex_t;

    // SUB exists only in the register form; ADDI ignores funct7.
    function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3,
                                             input logic       funct7b5,
                                             input logic       isReg);
        alu_ctrl_e op;
        case (funct3)
            3'b000:  op = (isReg && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr,
                                                   input imm_src_e   src);
        logic [XLEN-1:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports that bypass the same-cycle
// writeback, one synchronous write port, x0 hardwired to zero.
module register_file
    import riscv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            writeEn;

    assign writeEn = we_i && (waddr_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeEn) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // A write landing this edge is forwarded so decode never sees stale data.
    always_comb begin
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (writeEn && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = regs_q[raddr1_i];
        end
    end

    always_comb begin
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (writeEn && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate generation, register read, branch
// target, and the flushable ID/EX pipeline register feeding execute.
module decode_cycle
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              FlushE,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [XLEN-1:0]   ResultW,
    output logic [XLEN-1:0]   PcBranchD,
    output logic              BranchD,
    output logic              JumpD,
    output logic [REG_AW-1:0] Rs1D,
    output logic [REG_AW-1:0] Rs2D,
    output logic              IllegalD,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              MemToRegE,
    output logic              ALUSrcE,
    output logic              BranchE,
    output logic              BneE,
    output logic              JumpE,
    output logic [3:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            regWrite, memWrite, memToReg, aluSrc, branch, jump, knownOp;
    alu_ctrl_e       aluControl;
    imm_src_e        immSrc;
    logic [XLEN-1:0] immExt;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] rd1, rd2;
    idex_t           idex_d, idex_q;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];

    always_comb begin
        regWrite   = 1'b0;
        memWrite   = 1'b0;
        memToReg   = 1'b0;
        aluSrc     = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        knownOp    = 1'b1;
        aluControl = ALU_ADD;
        immSrc     = IMM_NONE;
        case (opcode)
            OP_R: begin
                regWrite   = 1'b1;
                aluControl = alu_decode(funct3, funct7b5, 1'b1);
            end
            OP_I: begin
                regWrite   = 1'b1;
                aluSrc     = 1'b1;
                immSrc     = IMM_I;
                aluControl = alu_decode(funct3, funct7b5, 1'b0);
            end
            OP_LOAD: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                aluSrc   = 1'b1;
                immSrc   = IMM_I;
            end
            OP_STORE: begin
                memWrite = 1'b1;
                aluSrc   = 1'b1;
                immSrc   = IMM_S;
            end
            OP_BRANCH: begin
                branch     = 1'b1;
                aluControl = ALU_SUB;
                immSrc     = IMM_B;
            end
            OP_JAL: begin
                jump     = 1'b1;
                regWrite = 1'b1;
                immSrc   = IMM_J;
            end
            OP_LUI: begin
                regWrite   = 1'b1;
                aluSrc     = 1'b1;
                immSrc     = IMM_U;
                aluControl = ALU_PASSB;
            end
            default: knownOp = 1'b0;
        endcase
    end

    // The all-zero word is fetch's reset bubble, not an illegal instruction.
    assign IllegalD  = !knownOp && (InstrD != 32'd0);
    assign BranchD   = branch;
    assign JumpD     = jump;
    assign immExt    = imm_extend(InstrD, immSrc);
    assign pcD       = PCPlus4D - 32'd4;
    assign PcBranchD = pcD + immExt;

    register_file u_regfile (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (RegWriteW),
        .waddr_i  (RdW),
        .wdata_i  (ResultW),
        .raddr1_i (Rs1D),
        .raddr2_i (Rs2D),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    always_comb begin
        idex_d            = '0;
        idex_d.regWrite   = regWrite;
        idex_d.memWrite   = memWrite;
        idex_d.memToReg   = memToReg;
        idex_d.aluSrc     = aluSrc;
        idex_d.branch     = branch;
        idex_d.bne        = branch && funct3[0];
        idex_d.jump       = jump;
        idex_d.aluControl = aluControl;
        idex_d.rd1        = rd1;
        idex_d.rd2        = rd2;
        idex_d.immExt     = immExt;
        idex_d.rs1        = Rs1D;
        idex_d.rs2        = Rs2D;
        idex_d.rd         = InstrD[11:7];
        idex_d.pc         = pcD;
        idex_d.pcPlus4    = PCPlus4D;
    end

    // A flush inserts an all-zero bubble, which execute treats as a NOP.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.regWrite;
    assign MemWriteE   = idex_q.memWrite;
    assign MemToRegE   = idex_q.memToReg;
    assign ALUSrcE     = idex_q.aluSrc;
    assign BranchE     = idex_q.branch;
    assign BneE        = idex_q.bne;
    assign JumpE       = idex_q.jump;
    assign ALUControlE = idex_q.aluControl;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.immExt;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pcPlus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios followed by random
// instructions, compared against a shadow register array and an arithmetic decode model.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] InstrD = '0, PCPlus4D = '0, ResultW = '0;
    logic        FlushE = 1'b0, RegWriteW = 1'b0;
    logic [4:0]  RdW = '0;

    logic [31:0] PcBranchD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic        BranchD, JumpD, IllegalD;
    logic        RegWriteE, MemWriteE, MemToRegE, ALUSrcE, BranchE, BneE, JumpE;
    logic [3:0]  ALUControlE;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .FlushE(FlushE),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .PcBranchD(PcBranchD), .BranchD(BranchD), .JumpD(JumpD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .IllegalD(IllegalD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .BneE(BneE), .JumpE(JumpE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] modelRegs [32];

    typedef struct {
        logic        regWrite, memWrite, memToReg, aluSrc, branch, bne, jump, illegal;
        logic [3:0]  alu;
        logic [31:0] imm;
    } dec_t;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode built from the instruction-set rules with integer arithmetic.
    function automatic dec_t modelDecode(input logic [31:0] ins);
        dec_t d;
        int   s, f3, hi;
        int   aluByF3 [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        d  = '{default: '0};
        s  = $signed(ins);
        f3 = int'(ins[14:12]);
        case (ins[6:0])
            7'h33: begin
                d.regWrite = 1;
                d.alu = 4'(aluByF3[f3]);
                if (ins[30] && f3 == 0) d.alu = 4'd1;
                if (ins[30] && f3 == 5) d.alu = 4'd7;
            end
            7'h13: begin
                d.regWrite = 1; d.aluSrc = 1;
                hi = s >>> 20; d.imm = hi;
                d.alu = 4'(aluByF3[f3]);
                if (ins[30] && f3 == 5) d.alu = 4'd7;
            end
            7'h03: begin
                d.regWrite = 1; d.memToReg = 1; d.aluSrc = 1;
                hi = s >>> 20; d.imm = hi;
            end
            7'h23: begin
                d.memWrite = 1; d.aluSrc = 1;
                hi = s >>> 25;
                d.imm = hi * 32 + int'(ins[11:7]);
            end
            7'h63: begin
                d.branch = 1; d.alu = 4'd1; d.bne = ins[12];
                hi = s >>> 31;
                d.imm = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            end
            7'h6F: begin
                d.jump = 1; d.regWrite = 1;
                hi = s >>> 31;
                d.imm = hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            end
            7'h37: begin
                d.regWrite = 1; d.aluSrc = 1; d.alu = 4'd10;
                d.imm = ins & 32'hFFFF_F000;
            end
            default: d.illegal = (ins != 32'd0);
        endcase
        return d;
    endfunction

    // Drive one decode cycle, check the combinational outputs, then the ID/EX outputs after the edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pcp4, input logic flush,
                                 input logic rw, input logic [4:0] rd, input logic [31:0] res,
                                 input logic r);
        dec_t        d;
        logic [4:0]  rs1, rs2;
        logic [31:0] v1, v2, pc;
        logic        bubble;
        @(negedge clk);
        InstrD = instr; PCPlus4D = pcp4; FlushE = flush;
        RegWriteW = rw; RdW = rd; ResultW = res; rst = r;
        #1;
        d   = modelDecode(instr);
        rs1 = instr[19:15];
        rs2 = instr[24:20];
        pc  = pcp4 - 32'd4;
        checkOutput("PcBranchD", PcBranchD, pc + d.imm);
        checkOutput("BranchD", 32'(BranchD), 32'(d.branch));
        checkOutput("JumpD", 32'(JumpD), 32'(d.jump));
        checkOutput("IllegalD", 32'(IllegalD), 32'(d.illegal));
        checkOutput("Rs1D", 32'(Rs1D), 32'(rs1));
        checkOutput("Rs2D", 32'(Rs2D), 32'(rs2));
        v1 = (rs1 == 0) ? 32'd0 : (rw && rd == rs1) ? res : modelRegs[rs1];
        v2 = (rs2 == 0) ? 32'd0 : (rw && rd == rs2) ? res : modelRegs[rs2];
        bubble = r || flush;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        end else if (rw && rd != 0) begin
            modelRegs[rd] = res;
        end
        checkOutput("RegWriteE", 32'(RegWriteE), bubble ? 32'd0 : 32'(d.regWrite));
        checkOutput("MemWriteE", 32'(MemWriteE), bubble ? 32'd0 : 32'(d.memWrite));
        checkOutput("MemToRegE", 32'(MemToRegE), bubble ? 32'd0 : 32'(d.memToReg));
        checkOutput("ALUSrcE", 32'(ALUSrcE), bubble ? 32'd0 : 32'(d.aluSrc));
        checkOutput("BranchE", 32'(BranchE), bubble ? 32'd0 : 32'(d.branch));
        checkOutput("BneE", 32'(BneE), bubble ? 32'd0 : 32'(d.bne));
        checkOutput("JumpE", 32'(JumpE), bubble ? 32'd0 : 32'(d.jump));
        checkOutput("ALUControlE", 32'(ALUControlE), bubble ? 32'd0 : 32'(d.alu));
        checkOutput("RD1E", RD1E, bubble ? 32'd0 : v1);
        checkOutput("RD2E", RD2E, bubble ? 32'd0 : v2);
        checkOutput("ImmExtE", ImmExtE, bubble ? 32'd0 : d.imm);
        checkOutput("Rs1E", 32'(Rs1E), bubble ? 32'd0 : 32'(rs1));
        checkOutput("Rs2E", 32'(Rs2E), bubble ? 32'd0 : 32'(rs2));
        checkOutput("RdE", 32'(RdE), bubble ? 32'd0 : 32'(instr[11:7]));
        checkOutput("PCE", PCE, bubble ? 32'd0 : pc);
        checkOutput("PCPlus4E", PCPlus4E, bubble ? 32'd0 : pcp4);
    endtask

    logic [6:0] opTable [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h7F, 7'h00};

    initial begin
        logic [31:0] rnd, instr;
        logic [4:0]  rdw;
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;

        $display("[TB] reset with random instructions");
        for (int i = 0; i < 2; i++) applyStimulus($urandom, $urandom, 1'b0, 1'b1, 5'(i + 3), $urandom, 1'b1);
        for (int i = 0; i < 32; i++) begin
            instr = {7'b0, 5'(i), 5'(i), 3'b000, 5'd0, 7'h33};
            applyStimulus(instr, 32'h40 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            checkOutput("t1_RD1E_zero", RD1E, 32'd0);
        end

        $display("[TB] writeback bypass");
        applyStimulus(32'h0052_8333, 32'h100, 1'b0, 1'b1, 5'd5, 32'h0000_00AA, 1'b0);
        checkOutput("t2_RD1E", RD1E, 32'h0000_00AA);
        checkOutput("t2_RD2E", RD2E, 32'h0000_00AA);
        checkOutput("t2_RegWriteE", 32'(RegWriteE), 32'd1);
        checkOutput("t2_ALUControlE", 32'(ALUControlE), 32'd0);
        checkOutput("t2_RdE", 32'(RdE), 32'd6);

        $display("[TB] x0 write discarded");
        applyStimulus(32'd0, 32'h4, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'hFFF0_0093, 32'h8, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t3_RD1E", RD1E, 32'd0);
        checkOutput("t3_ImmExtE", ImmExtE, 32'hFFFF_FFFF);
        checkOutput("t3_ALUSrcE", 32'(ALUSrcE), 32'd1);

        $display("[TB] branch target");
        applyStimulus(32'hFE00_0EE3, 32'h0000_0014, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t4_PcBranchD", PcBranchD, 32'h0000_000C);
        checkOutput("t4_BranchD", 32'(BranchD), 32'd1);
        checkOutput("t4_PCE", PCE, 32'h0000_0010);
        checkOutput("t4_BneE", 32'(BneE), 32'd0);

        $display("[TB] flush then capture");
        applyStimulus(32'h0020_A423, 32'h20, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t5_flush_MemWriteE", 32'(MemWriteE), 32'd0);
        checkOutput("t5_flush_PCPlus4E", PCPlus4E, 32'd0);
        applyStimulus(32'h0020_A423, 32'h20, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t5_MemWriteE", 32'(MemWriteE), 32'd1);
        checkOutput("t5_ImmExtE", ImmExtE, 32'd8);

        $display("[TB] illegal opcode and reset bubble");
        applyStimulus(32'h0000_007F, 32'h24, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t6_IllegalD", 32'(IllegalD), 32'd1);
        checkOutput("t6_RegWriteE", 32'(RegWriteE), 32'd0);
        applyStimulus(32'd0, 32'h28, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t6_zero_IllegalD", 32'(IllegalD), 32'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 500; n++) begin
            rnd   = $urandom;
            instr = {rnd[31:7], opTable[$urandom_range(0, 8)]};
            if (instr[6:0] == 7'h00) instr = 32'd0;
            rdw = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rdw = instr[19:15];
            applyStimulus(instr, $urandom, ($urandom_range(0, 7) == 0), 1'($urandom), rdw, $urandom,
                          ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Second stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage; consumes InstrD and PCPlus4D from the IF/ID register.
- Decodes the instruction and reads the 32x32 register file, which has a writeback-port bypass.
- Generates the sign-extended immediate and the branch/jump target PcBranchD that is returned to fetch.
- Holds the ID/EX pipeline register, with flush, that feeds the execute stage.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural register count; x0 hardwired to zero

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
InstrD  in  32  instruction from IF/ID
PCPlus4D  in  32  PC+4 from IF/ID
FlushE  in  1  clear ID/EX to a bubble on next edge (from hazard unit)
RegWriteW  in  1  writeback enable
RdW  in  5  writeback destination
ResultW  in  32  writeback data
PcBranchD  out  32  combinational target = (PCPlus4D - 4) + ImmExtD
BranchD  out  1  combinational: instruction is BEQ/BNE
JumpD  out  1  combinational: instruction is JAL
Rs1D  out  5  combinational InstrD[19:15], to hazard unit
Rs2D  out  5  combinational InstrD[24:20], to hazard unit
IllegalD  out  1  combinational: unsupported opcode
RegWriteE, MemWriteE, MemToRegE, ALUSrcE, BranchE, BneE, JumpE  out  1 each  registered control
ALUControlE  out  4  registered ALU op
RD1E  out  32  registered rs1 data
RD2E  out  32  registered rs2 data
ImmExtE  out  32  registered immediate
Rs1E  out  5  registered source index
Rs2E  out  5  registered source index
RdE  out  5  registered destination index
PCE  out  32  registered instruction PC (PCPlus4D - 4)
PCPlus4E  out  32  registered PC+4

Behaviour:
- Register file:
  - 32 entries, written on the rising clk edge when RegWriteW=1 and RdW!=0.
  - x0 always reads 0; writes to x0 are discarded.
  - Reads are combinational with bypass: if RegWriteW and RdW!=0 and RdW==rs, the read returns ResultW in the same cycle.
  - rst clears all 32 entries to 0.
- Decode, by opcode InstrD[6:0]:
  - 0110011 R-type: RegWrite=1, ALUSrc=0; funct3/funct7[5] select ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, I-immediate; funct7[5] is used only for SRAI.
  - 0000011 LW: RegWrite=1, MemToReg=1, ALUSrc=1, ALU=ADD.
  - 0100011 SW: MemWrite=1, ALUSrc=1, S-immediate, ALU=ADD.
  - 1100011 BEQ/BNE: Branch=1, ALU=SUB, B-immediate; BneE=funct3[0].
  - 1101111 JAL: Jump=1, RegWrite=1, J-immediate.
  - 0110111 LUI: RegWrite=1, ALUSrc=1, U-immediate, ALU=PASSB.
  - Any other opcode, including InstrD=0 (the fetch reset bubble): all control=0 and IllegalD=1, except IllegalD=0 when InstrD==0.
- Immediates are sign-extended from the instruction MSB; B and J immediates have bit0=0.
- PcBranchD is 32-bit modulo arithmetic; wrap-around is silent.
- ID/EX register, latency 1 cycle:
  - rst=1: every E output = 0.
  - else FlushE=1: every E output = 0 (bubble, behaves as NOP).
  - else: capture the decoded values.
  - Priority is rst > FlushE > capture.
- Simultaneous writeback and read of the same register: the bypass value is captured into RD1E/RD2E.
- Reset mid-operation: all state cleared on that edge; the first edge after rst deasserts captures normally.
- Combinational outputs are a pure function of the current inputs; they are not gated by rst, and InstrD is already 0 during reset.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI);
  - the 4-bit ALUControl encoding (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10);
  - the ImmSrc encoding (I, S, B, J, U).
- One sub-module: register_file (two combinational read ports with bypass, one synchronous write port, synchronous reset).
- Control decode and immediate generation stay inline.

Test Plan:
1. rst=1 for 2 cycles with random InstrD -> all E outputs 0; RD1E reads 0 for every register after release.
2. ResultW=0x0000_00AA, RdW=5, RegWriteW=1 the same cycle as InstrD=0x00528333 (add x6,x5,x5) -> next cycle RD1E=RD2E=0x0000_00AA (bypass), RegWriteE=1, ALUControlE=ADD, RdE=6.
3. Write x0 with 0xFFFF_FFFF, then decode addi x1,x0,-1 (0xFFF00093) -> RD1E=0, ImmExtE=0xFFFF_FFFF, ALUSrcE=1.
4. PCPlus4D=0x0000_0014, InstrD=0xFE000EE3 (beq x0,x0,-4) -> PcBranchD=0x0000_000C, BranchD=1 same cycle; next cycle PCE=0x0000_0010, BneE=0.
5. sw x2,8(x1) (0x0020A423) with FlushE=1 -> all E outputs 0; same instruction with FlushE=0 -> MemWriteE=1, ImmExtE=8.
6. InstrD=0x0000007F -> IllegalD=1 and all control E outputs 0 next cycle; InstrD=0 -> IllegalD=0.
